cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Round-robin arbiter and sequencer that shares one 8-bit dual-mode magnitude comparator (mode 0 unsigned, mode 1 two's-complement signed, result a > b) among N_REQ requesters. It sits between requesting datapath blocks and the comparator. It latches the winning requester's operands and mode, runs one registered compare, and returns the result with the requester's ID. It is the only path by which requesters reach the comparator.

## Interface
- N_REQ, 4, number of requesters (≥ 2); ID width IDW = $clog2(N_REQ)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  request per requester; held high until the matching gnt bit is seen
- a_in  in  8*N_REQ  operand a; requester i at bits [8*i +: 8]
- b_in  in  8*N_REQ  operand b; same packing
- mode_in  in  N_REQ  per-requester mode; 0 unsigned, 1 signed
- gnt  out  N_REQ  one-hot, 1-cycle pulse; operands of that requester were captured
- busy  out  1  high while state ≠ IDLE
- done  out  1  1-cycle pulse; result_agtb and done_id valid
- done_id  out  IDW  index of the requester whose compare completed
- result_agtb  out  1  compare result; holds until the next done

## Operation
- FSM states: IDLE, CMP, DONE.
- IDLE: if req ≠ 0, select the winner by round-robin search, starting at ptr and ascending with wrap to 0.
  - At the edge: latch a, b, mode and the winner ID into operand registers.
  - Set gnt to the winner's one-hot value.
  - Set ptr = (winner+1) mod N_REQ.
  - Go to CMP.
- If req = 0 in IDLE, remain in IDLE and leave ptr unchanged.
- CMP: the comparator sees only the latched operand registers. At the edge, register agtb into result_agtb, copy the latched ID to done_id, pulse done, and go to DONE.
- DONE: a single bookkeeping cycle; done is high here. Unconditionally go to IDLE.
- req is ignored outside IDLE. Operand changes after the grant edge do not affect the result.
- Compare semantics:
  - Unsigned: a > b as 0..255.
  - Signed: a > b as -128..127.
  - Equal operands give 0 in both modes.
- ptr resets to 0, so requester 0 has first priority after reset.

## Timing
- Cycle 0: IDLE with req ≠ 0. Cycle 1: gnt high, state CMP. Cycle 2: done high, state DONE, result valid. Cycle 3: IDLE, new arbitration.
- Result latency is 2 cycles from the sampled request. Peak throughput is one compare per 3 cycles.
- A requester must deassert its req by cycle 3 (i.e. in response to gnt) or it is re-granted when its round-robin turn comes.
- busy is high in cycles 1–2 and low in IDLE.
- Reset values: gnt = 0, done = 0, done_id = 0, result_agtb = 0, busy = 0, state = IDLE, ptr = 0.
- Reset asserted in CMP or DONE: return to IDLE and clear all outputs. No done is emitted for the aborted compare and its result is discarded.
- Simultaneous requests: exactly one gnt bit per arbitration; never more than one gnt bit set.
- Wrap-around: with ptr = N_REQ-1 and req = {req[N_REQ-1], req[0]}, requester N_REQ-1 wins and ptr wraps to 0.

## Test plan
- Reset: hold reset 3 cycles with all req = 1111 → gnt, done, busy, done_id and result_agtb all 0 during reset; first gnt = 0001 one cycle after reset release.
- Single compare: req = 0001, a0 = 0x0F, b0 = 0xF0.
  - mode 0 → gnt = 0001 at cycle 1, done at cycle 2 with result_agtb = 0 and done_id = 0.
  - Repeat with mode 1 → result_agtb = 1.
- Sign boundaries on requester 2:
  - a = 0x7F, b = 0x80: mode 0 → result_agtb = 0; mode 1 → result_agtb = 1.
  - a = b = 0x80 → result_agtb = 0 in both modes.
- Fairness: req = 1111 held continuously → grants in order 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart; each done_id matches its grant.
- Wrap and pointer: grant requester 3 alone, then req = 1001 → next grant is 0001. After that, req = 1001 again → grant is 1000.
- Reset mid-operation: assert reset during the CMP cycle of a requester-1 compare → no done pulse. Afterwards, req = 0011 → requester 0 is granted first (ptr back at 0).

Source files
------------

// File: rtl/cmp_arbiter_if.sv
// Bundle between the requesters and the shared comparator arbiter.
// The requester side drives requests and operands; the arbiter drives grants and results.
interface cmp_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] a_in;
  logic [8*N_REQ-1:0] b_in;
  logic [N_REQ-1:0]   mode_in;
  logic [N_REQ-1:0]   gnt;
  logic               busy;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic               result_agtb;

  modport master (
    output req, a_in, b_in, mode_in,
    input  gnt, busy, done, done_id, result_agtb
  );

  modport slave (
    input  req, a_in, b_in, mode_in,
    output gnt, busy, done, done_id, result_agtb
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit unsigned/signed a > b comparator.
// Each compare takes three cycles: grant, compare, bookkeeping.
module cmp_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic         clk,
  input  logic         reset,
  cmp_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [7:0]     a_reg;
  logic [7:0]     b_reg;
  logic           mode_reg;

  logic [IDW-1:0] cand_idx [N_REQ];
  logic           win_valid;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] ptr_next;
  logic           agtb;

  // Candidate gi is the requester gi places after ptr, wrapping at N_REQ.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand_idx[gi] = IDW'((int'(ptr_reg) + gi) % N_REQ);
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest active one wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[cand_idx[k]]) begin
        win_valid = 1'b1;
        win_id    = cand_idx[k];
      end
    end
  end

  assign ptr_next = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
  assign agtb     = mode_reg ? ($signed(a_reg) > $signed(b_reg)) : (a_reg > b_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      id_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      mode_reg        <= 1'b0;
      bus.gnt         <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.done_id     <= '0;
      bus.result_agtb <= 1'b0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            a_reg     <= bus.a_in[8*win_id +: 8];
            b_reg     <= bus.b_in[8*win_id +: 8];
            mode_reg  <= bus.mode_in[win_id];
            id_reg    <= win_id;
            bus.gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            ptr_reg   <= ptr_next;
            bus.busy  <= 1'b1;
            state_reg <= CMP;
          end
        end
        CMP: begin
          bus.result_agtb <= agtb;
          bus.done_id     <= id_reg;
          bus.done        <= 1'b1;
          state_reg       <= DONE;
        end
        DONE: begin
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          bus.busy  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: table of single compares plus reset, fairness,
// wrap-around and mid-operation reset sequences.
module tb_cmp_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmp_arbiter_if #(.N_REQ(N)) bus();
  cmp_arbiter #(.N_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] reqv;
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [3:0] exp_gnt;
    logic       exp_res;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic m);
    bus.a_in[8*id +: 8] = a;
    bus.b_in[8*id +: 8] = b;
    bus.mode_in[id]     = m;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 12 && g == 0; i++) begin
      @(negedge clk);
      g = bus.gnt;
    end
  endtask

  // One arbitration: request, see grant, drop request and disturb operands, see result.
  task automatic run_txn(input string nm, input logic [3:0] reqv, input logic [3:0] exp_gnt,
                         input int exp_id, input logic exp_res);
    logic [3:0] g;
    logic [8*N-1:0] tmp;
    bus.req = reqv;
    wait_gnt(g);
    check({nm, " gnt"}, 32'(g), 32'(exp_gnt));
    check({nm, " busy_cmp"}, 32'(bus.busy), 32'd1);
    check({nm, " done_early"}, 32'(bus.done), 32'd0);
    bus.req = '0;
    tmp = bus.a_in; bus.a_in = bus.b_in; bus.b_in = tmp;
    @(negedge clk);
    check({nm, " done"}, 32'(bus.done), 32'd1);
    check({nm, " done_id"}, 32'(bus.done_id), 32'(exp_id));
    check({nm, " result"}, 32'(bus.result_agtb), 32'(exp_res));
    $display("txn %s: req=%b gnt=%b done_id=%0d result=%0d", nm, reqv, g, bus.done_id, bus.result_agtb);
    @(negedge clk);
    check({nm, " done_clear"}, 32'(bus.done), 32'd0);
    check({nm, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] g;
  int last_cyc;
  logic exp_f[4];

  initial begin
    vecs[0] = '{4'b0001, 0, 8'h0F, 8'hF0, 1'b0, 4'b0001, 1'b0};
    vecs[1] = '{4'b0001, 0, 8'h0F, 8'hF0, 1'b1, 4'b0001, 1'b1};
    vecs[2] = '{4'b0100, 2, 8'h7F, 8'h80, 1'b0, 4'b0100, 1'b0};
    vecs[3] = '{4'b0100, 2, 8'h7F, 8'h80, 1'b1, 4'b0100, 1'b1};
    vecs[4] = '{4'b0100, 2, 8'h80, 8'h80, 1'b0, 4'b0100, 1'b0};
    vecs[5] = '{4'b0100, 2, 8'h80, 8'h80, 1'b1, 4'b0100, 1'b0};
    vecs[6] = '{4'b0010, 1, 8'h80, 8'h7F, 1'b0, 4'b0010, 1'b1};
    vecs[7] = '{4'b1000, 3, 8'hFF, 8'h00, 1'b1, 4'b1000, 1'b0};
    vecs[8] = '{4'b1000, 3, 8'hFF, 8'h00, 1'b0, 4'b1000, 1'b1};

    // Fairness operands: r0 unsigned 10>05, r1 unsigned 05>10, r2 signed 80>01, r3 unsigned 80>01
    set_op(0, 8'h10, 8'h05, 1'b0); exp_f[0] = 1'b1;
    set_op(1, 8'h05, 8'h10, 1'b0); exp_f[1] = 1'b0;
    set_op(2, 8'h80, 8'h01, 1'b1); exp_f[2] = 1'b0;
    set_op(3, 8'h80, 8'h01, 1'b0); exp_f[3] = 1'b1;

    reset   = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst gnt", 32'(bus.gnt), 32'd0);
      check("rst done", 32'(bus.done), 32'd0);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst done_id", 32'(bus.done_id), 32'd0);
      check("rst result", 32'(bus.result_agtb), 32'd0);
    end
    reset    = 1'b0;
    last_cyc = cyc;

    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      check("fair gnt", 32'(g), 32'(4'b0001 << (k % 4)));
      check("fair spacing", 32'(cyc - last_cyc), (k == 0) ? 32'd1 : 32'd3);
      last_cyc = cyc;
      if (k == 4) bus.req = '0;
      @(negedge clk);
      check("fair done", 32'(bus.done), 32'd1);
      check("fair done_id", 32'(bus.done_id), 32'(k % 4));
      check("fair result", 32'(bus.result_agtb), 32'(exp_f[k % 4]));
      $display("txn fair%0d: gnt=%b done_id=%0d result=%0d", k, g, bus.done_id, bus.result_agtb);
    end
    @(negedge clk);
    check("fair idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 9; i++) begin
      set_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].mode);
      run_txn($sformatf("vec%0d", i), vecs[i].reqv, vecs[i].exp_gnt, vecs[i].id, vecs[i].exp_res);
    end

    // Wrap: r3 alone resets ptr to 0, then 1001 picks r0, then 1001 picks r3.
    set_op(3, 8'h01, 8'h00, 1'b0);
    run_txn("wrap_r3", 4'b1000, 4'b1000, 3, 1'b1);
    set_op(0, 8'h00, 8'h01, 1'b0);
    set_op(3, 8'h01, 8'h00, 1'b0);
    run_txn("wrap_r0", 4'b1001, 4'b0001, 0, 1'b0);
    set_op(0, 8'h00, 8'h01, 1'b0);
    set_op(3, 8'h01, 8'h00, 1'b0);
    run_txn("wrap_r3b", 4'b1001, 4'b1000, 3, 1'b1);

    // Reset during the CMP cycle of a requester-1 compare.
    set_op(1, 8'h05, 8'h03, 1'b0);
    bus.req = 4'b0010;
    wait_gnt(g);
    check("abort gnt", 32'(g), 32'(4'b0010));
    reset   = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort result", 32'(bus.result_agtb), 32'd0);
    check("abort done_id", 32'(bus.done_id), 32'd0);
    @(negedge clk);
    check("abort done2", 32'(bus.done), 32'd0);
    reset = 1'b0;
    set_op(0, 8'h22, 8'h11, 1'b0);
    set_op(1, 8'h11, 8'h22, 1'b0);
    run_txn("post_rst", 4'b0011, 4'b0001, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
